// File: rtl/axis_i2s_tx.sv
// AXI4-Stream to I2S transmitter: 32-bit L/R stereo, 16-bit samples.
// Samples pass through a small FIFO; a 64-BCLK frame is shifted out.
//
// Ports:
//   ACLK, ARESETn          clock, async active-low reset
//   TVALID/TREADY/TDATA    stream slave; TDATA = {left, right}
//   TLAST                  accepted, ignored
//   UNDERFLOW_CLR          sync clear of UNDERFLOW
//   UNDERFLOW              sticky: frame start found FIFO empty
//   I2S_BCLK/LRCLK/SDATA   serial bit clock, word select, data
//
// Build option AXIS_I2S_TX_REPEAT_ON_UNDERRUN_EN:
//   defined   -> an underrun frame repeats the last sample
//   undefined -> an underrun frame is silence (zeros)

module axis_i2s_tx #(
  parameter int unsigned BCLK_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        TVALID,
  output logic        TREADY,
  input  logic [31:0] TDATA,
  input  logic        TLAST,
  input  logic        UNDERFLOW_CLR,
  output logic        UNDERFLOW,
  output logic        I2S_BCLK,
  output logic        I2S_LRCLK,
  output logic        I2S_SDATA
);

  localparam int unsigned AW = (FIFO_DEPTH > 1)
                             ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0]    DIV_MAX = 8'(BCLK_DIV - 1);
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

  logic [7:0]    div_cnt_q, div_cnt_d;
  logic          bclk_q,    bclk_d;
  logic          lrclk_q,   lrclk_d;
  logic          sdata_q,   sdata_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   frame_q,   frame_d;
  logic          uflow_q,   uflow_d;
  logic          tready_q,  tready_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0] count_q,   count_d;

  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          tick;
  logic          fall;
  logic          wr_en;
  logic          pop;
  logic          urun;
  logic [5:0]    k;
  logic [5:0]    sel;

  logic          unused_tlast;

  assign unused_tlast = TLAST;

  assign tick  = (div_cnt_q == DIV_MAX);
  assign fall  = tick & bclk_q;
  assign wr_en = TVALID & tready_q;
  assign k     = bit_cnt_q + 6'd1;

  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pop       = 1'b0;
    urun      = 1'b0;
    sel       = 6'd0;

    if (tick) begin
      div_cnt_d = 8'd0;
      bclk_d    = ~bclk_q;
    end

    if (fall) begin
      bit_cnt_d = k;

      if (k == 6'd0) begin
        lrclk_d = 1'b0;
        if (count_q != '0) begin
          pop     = 1'b1;
          frame_d = mem_q[rd_ptr_q];
        end else begin
          urun = 1'b1;
`ifdef AXIS_I2S_TX_REPEAT_ON_UNDERRUN_EN
          frame_d = frame_q;
`else
          frame_d = 32'h0;
`endif
        end
      end

      if (k == 6'd32) begin
        lrclk_d = 1'b1;
      end

      // The frame register is already loaded at k=0,
      // so the data bits read the current frame_q.
      unique case (1'b1)
        (k >= 6'd1 && k <= 6'd16): begin
          sel     = 6'd32 - k;
          sdata_d = frame_q[sel[4:0]];
        end
        (k >= 6'd33 && k <= 6'd48): begin
          sel     = 6'd48 - k;
          sdata_d = frame_q[sel[4:0]];
        end
        default: begin
          sdata_d = 1'b0;
        end
      endcase
    end

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Registered ready from next-state fill level:
    // no TVALID-to-TREADY path, never overfills.
    tready_d = (count_d != FULL);

    // A new underrun beats a same-cycle clear.
    uflow_d = uflow_q;
    if (UNDERFLOW_CLR) begin
      uflow_d = 1'b0;
    end
    if (urun) begin
      uflow_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      div_cnt_q <= 8'd0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
      sdata_q   <= 1'b0;
      bit_cnt_q <= 6'd63;
      frame_q   <= 32'h0;
      uflow_q   <= 1'b0;
      tready_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      uflow_q   <= uflow_d;
      tready_q  <= tready_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: pointers define emptiness.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= TDATA;
    end
  end

  assign TREADY    = tready_q;
  assign UNDERFLOW = uflow_q;
  assign I2S_BCLK  = bclk_q;
  assign I2S_LRCLK = lrclk_q;
  assign I2S_SDATA = sdata_q;

endmodule

// File: tb/tb_axis_i2s_tx.sv
// Testbench for axis_i2s_tx: directed stimulus, expected frames
// queued per send, decoded from the I2S lines by a monitor.

module tb_axis_i2s_tx;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        TVALID = 1'b0;
  logic        TREADY;
  logic [31:0] TDATA = 32'h0;
  logic        TLAST = 1'b0;
  logic        UNDERFLOW_CLR = 1'b0;
  logic        UNDERFLOW;
  logic        I2S_BCLK;
  logic        I2S_LRCLK;
  logic        I2S_SDATA;

`ifdef AXIS_I2S_TX_REPEAT_ON_UNDERRUN_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc;
  int pos;

  axis_i2s_tx #(
    .BCLK_DIV  (4),
    .FIFO_DEPTH(4)
  ) dut (
    .ACLK         (ACLK),
    .ARESETn      (ARESETn),
    .TVALID       (TVALID),
    .TREADY       (TREADY),
    .TDATA        (TDATA),
    .TLAST        (TLAST),
    .UNDERFLOW_CLR(UNDERFLOW_CLR),
    .UNDERFLOW    (UNDERFLOW),
    .I2S_BCLK     (I2S_BCLK),
    .I2S_LRCLK    (I2S_LRCLK),
    .I2S_SDATA    (I2S_SDATA)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: an I2S receiver sampling on BCLK rising edges.
  logic        prev_bclk;
  logic        prev_lr;
  logic [15:0] l_sh;
  logic [15:0] r_sh;
  bit          fmt_ok;
  exp_t        e;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      pos       = -1;
      prev_bclk = 1'b0;
      prev_lr   = 1'b1;
    end else begin
      if (I2S_BCLK && !prev_bclk) begin
        if (!I2S_LRCLK && prev_lr) pos = 0;
        else if (pos >= 0)         pos++;
        prev_lr = I2S_LRCLK;
        if (pos == 0) begin
          fmt_ok = 1'b1;
          l_sh   = 16'h0;
          r_sh   = 16'h0;
        end
        if (pos >= 0 && pos <= 48) begin
          if (I2S_LRCLK != (pos >= 32)) fmt_ok = 1'b0;
          if (pos >= 1 && pos <= 16)
            l_sh[16-pos] = I2S_SDATA;
          else if (pos >= 33 && pos <= 48)
            r_sh[48-pos] = I2S_SDATA;
          else if (I2S_SDATA !== 1'b0)
            fmt_ok = 1'b0;
          if (pos == 48 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_data", {l_sh, r_sh}, e.data);
            check("frame_uflow", {31'h0, UNDERFLOW},
                  {31'h0, e.uf});
            check("frame_format", {31'h0, fmt_ok}, 32'h1);
          end
        end
      end
      prev_bclk = I2S_BCLK;
    end
  end

  task automatic push(input logic [31:0] d, input logic uf);
    exp_t x;
    x.data = d;
    x.uf   = uf;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    #2;
    ARESETn = 1'b0;
    TVALID = 1'b0;
    UNDERFLOW_CLR = 1'b0;
    #1;
    check("rst_tready", {31'h0, TREADY},    32'h0);
    check("rst_bclk",   {31'h0, I2S_BCLK},  32'h0);
    check("rst_lrclk",  {31'h0, I2S_LRCLK}, 32'h1);
    check("rst_sdata",  {31'h0, I2S_SDATA}, 32'h0);
    check("rst_uflow",  {31'h0, UNDERFLOW}, 32'h0);
    exp_q.delete();
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
    check("tready_after_rst", {31'h0, TREADY}, 32'h1);
  endtask

  // Holds TVALID until the beat is taken; leaves TVALID high.
  task automatic send(input logic [31:0] d);
    bit done;
    done = 1'b0;
    @(negedge ACLK);
    TVALID = 1'b1;
    TDATA  = d;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (TREADY) begin
        @(posedge ACLK);
        done = 1'b1;
      end else begin
        @(negedge ACLK);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic idle();
    #1;
    TVALID = 1'b0;
  endtask

  // Drives one beat so that it is taken on edge number c.
  task automatic send_at(input int c, input logic [31:0] d);
    for (int i = 0; i < 3000 && cyc != c - 1; i++)
      @(negedge ACLK);
    check("send_at_cycle", cyc, c - 1);
    check("send_at_ready", {31'h0, TREADY}, 32'h1);
    TVALID = 1'b1;
    TDATA  = d;
    @(posedge ACLK);
    idle();
  endtask

  task automatic wait_level(input int which, input logic lvl,
                            output int at);
    logic v;
    at = -1;
    for (int i = 0; i < 2000 && at < 0; i++) begin
      @(negedge ACLK);
      v = (which == 0) ? I2S_BCLK : I2S_LRCLK;
      if (v == lvl) at = cyc;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_level: got timeout expected level %0d",
               lvl);
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++)
      @(negedge ACLK);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic pulse_clr(input logic req_uf);
    @(negedge ACLK);
    UNDERFLOW_CLR = 1'b1;
    @(posedge ACLK);
    #1;
    UNDERFLOW_CLR = 1'b0;
    check("uflow_after_clr", {31'h0, UNDERFLOW},
          {31'h0, req_uf});
  endtask

  logic [31:0] bp_vec [10] = '{
    32'h1111_EEEE, 32'h2222_DDDD, 32'h3333_CCCC,
    32'h4444_BBBB, 32'h5555_AAAA, 32'h6666_9999,
    32'h7777_8888, 32'h8001_7FFE, 32'h0F0F_F0F0,
    32'hDEAD_BEEF
  };

  initial begin
    int t1, t2, t3;

    // Post-reset timing and one known frame.
    do_reset();
    push(32'hA5A5_3C3C, 1'b0);
    send(32'hA5A5_3C3C);
    idle();
    wait_level(0, 1'b1, t1);
    check("bclk_first_rise", t1, 4);
    wait_level(1, 1'b0, t3);
    check("lrclk_fall_cycle", t3, 8);
    wait_level(0, 1'b1, t2);
    check("bclk_period", t2 - t1, 8);
    wait_drain(1500);

    // Back-pressure: 4 beats fill the FIFO before frame 1.
    do_reset();
    for (int i = 0; i < 10; i++) push(bp_vec[i], 1'b0);
    for (int i = 0; i < 4; i++) send(bp_vec[i]);
    idle();
    check("tready_full", {31'h0, TREADY}, 32'h0);
    t1 = -1;
    for (int i = 0; i < 100 && t1 < 0; i++) begin
      @(negedge ACLK);
      if (TREADY) t1 = cyc;
    end
    check("tready_return_cycle", t1, 8);
    for (int i = 4; i < 10; i++) send(bp_vec[i]);
    idle();
    wait_drain(7000);

    // Underrun after one sample, then flag clear behaviour.
    do_reset();
    push(32'h8000_7FFF, 1'b0);
    push(REP ? 32'h8000_7FFF : 32'h0, 1'b1);
    send(32'h8000_7FFF);
    idle();
    wait_drain(2000);
    check("uflow_set", {31'h0, UNDERFLOW}, 32'h1);
    pulse_clr(1'b0);
    push(REP ? 32'h8000_7FFF : 32'h0, 1'b1);
    wait_drain(1500);
    send(32'h5A5A_0F0F);
    idle();
    pulse_clr(1'b0);
    push(32'h5A5A_0F0F, 1'b0);
    wait_drain(1500);

    // Mid-frame reset must drop the queued sample.
    do_reset();
    send(32'h1234_5678);
    send(32'h9ABC_DEF0);
    idle();
    for (int i = 0; i < 2000 && pos != 20; i++)
      @(negedge ACLK);
    check("reached_bit20", pos, 20);
    do_reset();
    push(32'h0F0F_F0F0, 1'b0);
    push(REP ? 32'h0F0F_F0F0 : 32'h0, 1'b1);
    send(32'h0F0F_F0F0);
    idle();
    wait_drain(2000);

    // Same-cycle write and pop, with 1 entry then 0 entries.
    do_reset();
    push(32'hAAAA_0001, 1'b0);
    push(32'hBBBB_0002, 1'b0);
    push(REP ? 32'hBBBB_0002 : 32'h0, 1'b1);
    push(32'hCCCC_0003, 1'b1);
    send(32'hAAAA_0001);
    idle();
    send_at(8, 32'hBBBB_0002);
    send_at(1032, 32'hCCCC_0003);
    wait_drain(2000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
